// File: rtl/lockstep_chk_pkg.sv
// Shared types and helpers for the lockstep golden-vs-netlist vector checker.
package lockstep_chk_pkg;

    typedef enum logic [1:0] {StIdle, StRstHold, StRun, StDone} state_e;

    localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;
    localparam logic [31:0] DEFAULT_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l, input logic [31:0] poly);
        return (l >> 1) ^ (l[0] ? poly : 32'h0);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// 32-bit Galois LFSR with synchronous reload-to-seed and single-step advance.
module lfsr_galois
    import lockstep_chk_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED,
    parameter logic [31:0] POLY = DEFAULT_POLY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    output logic [31:0] state
);

    logic [31:0] state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEED;
        end else if (load) begin
            state_q <= SEED;
        end else if (advance) begin
            state_q <= lfsr_next(state_q, POLY);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lockstep_vector_checker.sv
// Drives LFSR vectors into golden and netlist instances, compares after a settle
// delay, counts mismatches and captures the first failing vector.
module lockstep_vector_checker
    import lockstep_chk_pkg::*;
#(
    parameter int unsigned IN_W    = 32,
    parameter int unsigned OUT_W   = 32,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned RST_CYC = 2,
    parameter int unsigned NUM_VEC = 1000,
    parameter int unsigned CNT_W   = 16,
    parameter logic [31:0] SEED    = DEFAULT_SEED,
    parameter logic [31:0] POLY    = DEFAULT_POLY,
    localparam int unsigned IDX_W  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  stim_o,
    output logic             dut_rst_o,
    input  logic [OUT_W-1:0] gold_i,
    input  logic [OUT_W-1:0] dut_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [IDX_W-1:0] vec_idx,
    output logic [IDX_W-1:0] first_idx,
    output logic [OUT_W-1:0] first_gold,
    output logic [OUT_W-1:0] first_dut,
    output logic             first_valid
);

    localparam int unsigned HOLD_W = $clog2(RST_CYC + 1);
    localparam int unsigned SET_W  = $clog2(SETTLE + 1);

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [IN_W-1:0]    stim_q, stim_d;
    logic [IDX_W-1:0]   idx_q, idx_d, fidx_q, fidx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   fgold_q, fgold_d, fdut_q, fdut_d;
    logic               fvalid_q, fvalid_d;
    logic               lfsr_load, lfsr_adv;
    logic [31:0]        lfsr_state;

    lfsr_galois #(
        .SEED(SEED),
        .POLY(POLY)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .advance(lfsr_adv),
        .state  (lfsr_state)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        settle_d  = settle_q;
        stim_d    = stim_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        fidx_d    = fidx_q;
        fgold_d   = fgold_q;
        fdut_d    = fdut_q;
        fvalid_d  = fvalid_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                // abort wins over a coincident start
                if (start && !abort) begin
                    state_d   = StRstHold;
                    hold_d    = '0;
                    settle_d  = '0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    fidx_d    = '0;
                    fgold_d   = '0;
                    fdut_d    = '0;
                    fvalid_d  = 1'b0;
                    lfsr_load = 1'b1;
                end
            end
            StRstHold: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (hold_q == HOLD_W'(RST_CYC - 1)) begin
                    state_d  = StRun;
                    stim_d   = lfsr_state[IN_W-1:0];
                    lfsr_adv = 1'b1;
                    idx_d    = '0;
                    settle_d = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (settle_q == SET_W'(SETTLE - 1)) begin
                    settle_d = '0;
                    if (gold_i != dut_i) begin
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                        if (!fvalid_q) begin
                            fvalid_d = 1'b1;
                            fidx_d   = idx_q;
                            fgold_d  = gold_i;
                            fdut_d   = dut_i;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_VEC - 1)) begin
                        state_d = StDone;
                    end else begin
                        stim_d   = lfsr_state[IN_W-1:0];
                        lfsr_adv = 1'b1;
                        idx_d    = idx_q + IDX_W'(1);
                    end
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            settle_q <= '0;
            stim_q   <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            fidx_q   <= '0;
            fgold_q  <= '0;
            fdut_q   <= '0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            settle_q <= settle_d;
            stim_q   <= stim_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            fidx_q   <= fidx_d;
            fgold_q  <= fgold_d;
            fdut_q   <= fdut_d;
            fvalid_q <= fvalid_d;
        end
    end

    // stim_q keeps the last vector after an abort; mask it while idle or holding reset
    assign stim_o       = (state_q == StRun || state_q == StDone) ? stim_q : '0;
    assign dut_rst_o    = (state_q == StIdle || state_q == StRstHold);
    assign busy         = (state_q == StRstHold || state_q == StRun);
    assign done         = (state_q == StDone);
    assign pass         = done && (cnt_q == '0);
    assign mismatch_cnt = cnt_q;
    assign vec_idx      = idx_q;
    assign first_idx    = fidx_q;
    assign first_gold   = fgold_q;
    assign first_dut    = fdut_q;
    assign first_valid  = fvalid_q;

endmodule

// File: doc/lockstep_vector_checker.md
Name: lockstep_vector_checker

Overview:
- Synthesizable self-checking harness for the golden-vs-post-route equivalence flow, parametrised in data width, settle time and vector count.
- Drives pseudo-random stimulus and a reset sequence into two design instances.
- Compares their outputs after a programmable settle delay and counts mismatches (saturating).
- Captures the first failing vector and reports pass/fail. Sits between the stimulus source and the golden/netlist instances, in place of the hand-written compare loop.

Parameters:
- IN_W, 32, stimulus width, 2..32.
- OUT_W, 32, compared output width, 1..64.
- SETTLE, 2, cycles from a stimulus change to its compare sample, >=1.
- RST_CYC, 2, cycles dut_rst_o is held asserted before the first vector, >=1.
- NUM_VEC, 1000, vectors per run, >=1.
- CNT_W, 16, mismatch counter width.
- SEED, 32'h0000_0001, LFSR seed, nonzero.
- POLY, 32'h8020_0003, Galois LFSR tap mask.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- abort  in  1  terminates a run and returns to IDLE
- stim_o  out  IN_W  stimulus to both instances
- dut_rst_o  out  1  active-high reset to both instances
- gold_i  in  OUT_W  golden output
- dut_i  in  OUT_W  netlist output
- busy  out  1  run in progress
- done  out  1  run finished; held until the next start
- pass  out  1  valid when done; 1 iff mismatch_cnt==0
- mismatch_cnt  out  CNT_W  saturating mismatch count
- vec_idx  out  clog2(NUM_VEC)  index of the current vector
- first_idx  out  clog2(NUM_VEC)  index of the first mismatching vector
- first_gold, first_dut  out  OUT_W  captured values at the first mismatch
- first_valid  out  1  a first mismatch has been captured

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE. All outputs are 0 except dut_rst_o=1.
  - LFSR loads SEED.
- FSM states: IDLE, RST_HOLD, RUN, DONE.
- IDLE:
  - dut_rst_o=1, stim_o=0, busy=0.
  - On start: go to RST_HOLD, clear mismatch_cnt, first_*, vec_idx and done; reload the LFSR with SEED.
- RST_HOLD:
  - busy=1, dut_rst_o=1, stim_o=0, held for RST_CYC cycles.
  - At the exit edge: dut_rst_o goes to 0, stim_o takes the LFSR value (low IN_W bits), the LFSR advances, vec_idx=0. Go to RUN.
- LFSR:
  - 32-bit Galois, advanced once per vector: next = (l>>1) ^ (l[0] ? POLY : 0).
  - Vector k's stimulus is the k-th state. With defaults: vector0=0x00000001, vector1=0x80200003, vector2=0xC0300002.
- RUN:
  - A settle counter counts SETTLE cycles after each stimulus change.
  - At the edge where it expires, gold_i and dut_i are sampled.
  - Mismatch test is a bitwise 4-state-free compare, gold_i != dut_i.
  - On a mismatch: mismatch_cnt increments, saturating at 2^CNT_W-1 with no wrap.
  - If first_valid=0 on that mismatch: capture vec_idx, gold_i and dut_i, and set first_valid. Later mismatches never overwrite the capture.
  - At the same edge, the next vector is loaded and vec_idx increments. The vector period is exactly SETTLE cycles.
  - The compare of vector NUM_VEC-1 goes to DONE; no further stimulus change.
- DONE:
  - busy=0, done=1, pass=(mismatch_cnt==0).
  - stim_o holds the last value; dut_rst_o=0.
  - Results are held until start, which begins a new run exactly as from IDLE.
- Start or abort collisions:
  - start while busy is ignored.
  - abort has priority over start and over a same-cycle compare: that vector is not counted.
  - abort from RST_HOLD or RUN goes to IDLE next edge. done stays 0; counters and first_* hold their values for inspection until the next start.
  - abort in IDLE or DONE is a no-op.
- Run length: RST_CYC + NUM_VEC*SETTLE cycles from the start edge to done=1.

Decomposition:
- Package lockstep_chk_pkg holds:
  - state enum (IDLE, RST_HOLD, RUN, DONE);
  - default POLY/SEED constants;
  - function lfsr_next(l, poly).
- One sub-module: lfsr_galois (32-bit, load/advance enables, POLY/SEED parameters). The FSM, counters and capture logic stay in the top.

Test Plan:
- Match run: gold_i and dut_i driven by the same combinational function of stim_o, default params -> done after 2+1000*2 cycles, pass=1, mismatch_cnt=0, first_valid=0; stim_o sequence starts 0x1, 0x80200003, 0xC0300002.
- Single fault: dut_i = gold_i ^ 1 only while vec_idx==5 -> mismatch_cnt=1, first_idx=5, first_dut = first_gold ^ 1, pass=0.
- Saturation: CNT_W=4, NUM_VEC=40, dut_i always inverted -> mismatch_cnt=15, first_idx=0.
- Abort: abort pulsed at vector 10 together with an injected mismatch -> IDLE next cycle, busy=0, done=0, mismatch_cnt=0; start during the run is ignored.
- Async reset mid-run: rst low at vector 300 between edges -> outputs clear immediately, dut_rst_o=1; after release and start, the sequence restarts at 0x00000001.
- SETTLE=1, NUM_VEC=1 -> done exactly RST_CYC+1 cycles after start; start in DONE reruns and clears first_valid.
